// File: rtl/matmul_loop_sequencer.sv
// matmul_loop_sequencer: walks the i/j/k triple loop of C = A x B for NxN
// matrices, producing registered A/B/C addresses plus the accumulate-clear,
// accumulate-enable and result-write strobes for the MAC datapath.
// Optional feature: define MATSEQ_STALL_EN to add a 'stall' input that
// freezes the sequencer (outside IDLE) while high.
module matmul_loop_sequencer #(
  parameter int N      = 4,
  parameter int AW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef MATSEQ_STALL_EN
  input  logic          stall,
`endif
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic          rd_en,
  output logic          mac_clr,
  output logic          mac_en,
  output logic [AW-1:0] addr_c,
  output logic          c_we
);

  localparam int              CW         = $clog2(N);
  localparam logic [CW-1:0]   LAST       = CW'(N - 1);
  localparam logic [AW-1:0]   STEP       = AW'(N);
  localparam logic [1:0]      DRAIN_LAST = 2'((RD_LAT > 0) ? (RD_LAT - 1) : 0);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MAC,
    DRAIN,
    WRITE,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   i_q, i_d;
  logic [CW-1:0]   j_q, j_d;
  logic [CW-1:0]   k_q, k_d;
  logic [AW-1:0]   row_base_q, row_base_d;
  logic [AW-1:0]   col_off_q, col_off_d;
  logic [1:0]      drain_q, drain_d;
  logic [AW-1:0]   addr_a_q, addr_a_d;
  logic [AW-1:0]   addr_b_q, addr_b_d;
  logic [AW-1:0]   addr_c_q, addr_c_d;
  logic            stall_in;
  logic            hold;

`ifdef MATSEQ_STALL_EN
  assign stall_in = stall;
`else
  assign stall_in = 1'b0;
`endif

  // A stall only freezes an active run; IDLE always reacts to start.
  assign hold = stall_in & (state_q != IDLE);

  assign busy    = (state_q == CLEAR) | (state_q == MAC) |
                   (state_q == DRAIN) | (state_q == WRITE);
  assign done    = (state_q == DONE);
  assign rd_en   = (state_q == MAC)   & ~hold;
  assign mac_clr = (state_q == CLEAR) & ~hold;
  assign c_we    = (state_q == WRITE) & ~hold;
  assign addr_a  = addr_a_q;
  assign addr_b  = addr_b_q;
  assign addr_c  = addr_c_q;

  // Next-state and counter logic; addresses are computed one cycle ahead so
  // the registered outputs line up with the MAC and WRITE cycles they serve.
  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    row_base_d = row_base_q;
    col_off_d  = col_off_q;
    drain_d    = drain_q;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    addr_c_d   = addr_c_q;
    if (!hold) begin
      unique case (state_q)
        IDLE: begin
          if (start) state_d = CLEAR;
        end
        CLEAR: begin
          k_d       = '0;
          col_off_d = '0;
          addr_a_d  = row_base_q;
          addr_b_d  = AW'(j_q);
          state_d   = MAC;
        end
        MAC: begin
          if (k_q == LAST) begin
            drain_d = '0;
            if (RD_LAT > 0) begin
              state_d = DRAIN;
            end else begin
              state_d  = WRITE;
              addr_c_d = row_base_q + AW'(j_q);
            end
          end else begin
            k_d       = k_q + CW'(1);
            col_off_d = col_off_q + STEP;
            addr_a_d  = row_base_q + AW'(k_q) + AW'(1);
            addr_b_d  = col_off_q + STEP + AW'(j_q);
          end
        end
        DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_d  = WRITE;
            addr_c_d = row_base_q + AW'(j_q);
          end else begin
            drain_d = drain_q + 2'd1;
          end
        end
        WRITE: begin
          state_d = CLEAR;
          if (j_q == LAST) begin
            j_d = '0;
            if (i_q == LAST) begin
              i_d        = '0;
              row_base_d = '0;
              state_d    = DONE;
            end else begin
              i_d        = i_q + CW'(1);
              row_base_d = row_base_q + STEP;
            end
          end else begin
            j_d = j_q + CW'(1);
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, counter and address registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      row_base_q <= '0;
      col_off_q  <= '0;
      drain_q    <= '0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      addr_c_q   <= '0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      row_base_q <= row_base_d;
      col_off_q  <= col_off_d;
      drain_q    <= drain_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      addr_c_q   <= addr_c_d;
    end
  end

  generate
    if (RD_LAT == 0) begin : g_no_lat
      assign mac_en = rd_en;
    end else begin : g_lat
      logic [RD_LAT-1:0] pipe_q, pipe_d;

      // Delay line aligning mac_en with the memory read data; flushed in CLEAR.
      always_comb begin
        pipe_d = pipe_q;
        if (!hold) begin
          if (state_q == CLEAR) begin
            pipe_d = '0;
          end else begin
            pipe_d[0] = rd_en;
            for (int b = 1; b < RD_LAT; b++) begin
              pipe_d[b] = pipe_q[b-1];
            end
          end
        end
      end

      // Delay-line register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pipe_q <= '0;
        else        pipe_q <= pipe_d;
      end

      assign mac_en = pipe_q[RD_LAT-1] & ~hold;
    end
  endgenerate

endmodule

// File: tb/tb_matmul_loop_sequencer.sv
// Testbench for matmul_loop_sequencer: three instances with different
// N/RD_LAT/AW, each checked every cycle against a positional model of the
// loop nest, plus literal expectations for the documented scenarios.
// With MATSEQ_STALL_EN defined the random phase also drives stall.
module tb_matmul_loop_sequencer;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       rd_en;
    logic       mac_clr;
    logic       mac_en;
    logic       c_we;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] start_v = '0;
  logic [2:0] stall_v = '0;

  int n_cmp = 0;
  int n_err = 0;

  logic       busy0, done0, rd0, clr0, en0, we0;
  logic [7:0] a0, b0, c0;
  logic       busy1, done1, rd1, clr1, en1, we1;
  logic [7:0] a1, b1, c1;
  logic       busy2, done2, rd2, clr2, en2, we2;
  logic [3:0] a2, b2, c2;

  obs_t dut_obs [3];
  assign dut_obs[0] = {busy0, done0, rd0, clr0, en0, we0, a0, b0, c0};
  assign dut_obs[1] = {busy1, done1, rd1, clr1, en1, we1, a1, b1, c1};
  assign dut_obs[2] = {busy2, done2, rd2, clr2, en2, we2, 4'h0, a2, 4'h0, b2, 4'h0, c2};

  always #5 clk = ~clk;

  matmul_loop_sequencer #(.N(2), .AW(8), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]),
`ifdef MATSEQ_STALL_EN
    .stall(stall_v[0]),
`endif
    .busy(busy0), .done(done0), .addr_a(a0), .addr_b(b0), .rd_en(rd0),
    .mac_clr(clr0), .mac_en(en0), .addr_c(c0), .c_we(we0));

  matmul_loop_sequencer #(.N(3), .AW(8), .RD_LAT(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]),
`ifdef MATSEQ_STALL_EN
    .stall(stall_v[1]),
`endif
    .busy(busy1), .done(done1), .addr_a(a1), .addr_b(b1), .rd_en(rd1),
    .mac_clr(clr1), .mac_en(en1), .addr_c(c1), .c_we(we1));

  matmul_loop_sequencer #(.N(4), .AW(4), .RD_LAT(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]),
`ifdef MATSEQ_STALL_EN
    .stall(stall_v[2]),
`endif
    .busy(busy2), .done(done2), .addr_a(a2), .addr_b(b2), .rd_en(rd2),
    .mac_clr(clr2), .mac_en(en2), .addr_c(c2), .c_we(we2));

  // Comparison bookkeeping shared by the per-cycle checker and the literals.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive start/stall masks for the coming clock edge.
  task automatic applyStimulus(input logic [2:0] starts, input logic [2:0] stalls);
    @(posedge clk);
    #2;
    start_v = starts;
    stall_v = stalls;
  endtask

  // Expected outputs t cycles after the idle cycle in which start was seen.
  // Each element (i,j), taken in row-major order, occupies CLEAR, N MAC cycles,
  // RD_LAT drain cycles and one WRITE; addresses otherwise keep their last value.
  function automatic obs_t model_out(input int n, input int lat, input int t, input obs_t held);
    obs_t o;
    int len, e, p, i, j, ep;
    o = '0;
    o.a = held.a;
    o.b = held.b;
    o.c = held.c;
    len = n + lat + 2;
    if (t <= 0) return o;
    if (t == len * n * n + 1) begin
      o.done = 1'b1;
      o.a = 8'(n * n - 1);
      o.b = 8'(n * n - 1);
      o.c = 8'(n * n - 1);
      return o;
    end
    e  = (t - 1) / len;
    p  = (t - 1) % len;
    i  = e / n;
    j  = e % n;
    ep = e - 1;
    o.busy = 1'b1;
    if (p >= 1 && p <= n) begin
      o.rd_en = 1'b1;
      o.a = 8'(i * n + p - 1);
      o.b = 8'((p - 1) * n + j);
    end else if (p > n) begin
      o.a = 8'(i * n + n - 1);
      o.b = 8'((n - 1) * n + j);
    end else if (e > 0) begin
      o.a = 8'((ep / n) * n + n - 1);
      o.b = 8'((n - 1) * n + ep % n);
    end
    if (p == n + lat + 1) begin
      o.c_we = 1'b1;
      o.c = 8'(i * n + j);
    end else if (e > 0) begin
      o.c = 8'(ep);
    end
    o.mac_clr = (p == 0);
    o.mac_en  = (p - lat >= 1) && (p - lat <= n);
    return o;
  endfunction

  int   nn [3] = '{2, 3, 4};
  int   ll [3] = '{1, 0, 3};
  bit   act [3] = '{0, 0, 0};
  int   tt [3] = '{0, 0, 0};
  obs_t held [3] = '{'0, '0, '0};
  obs_t exp_v;

  // Per-cycle comparison of every instance against the model.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        exp_v = '0;
        act[d] = 1'b0;
        tt[d] = 0;
        held[d] = '0;
      end else if (!act[d]) begin
        exp_v = model_out(nn[d], ll[d], 0, held[d]);
        if (start_v[d]) begin
          act[d] = 1'b1;
          tt[d] = 1;
        end
      end else begin
        exp_v = model_out(nn[d], ll[d], tt[d], held[d]);
        if (stall_v[d]) begin
          exp_v.rd_en = 1'b0;
          exp_v.mac_clr = 1'b0;
          exp_v.c_we = 1'b0;
          exp_v.mac_en = 1'b0;
        end else if (exp_v.done) begin
          act[d] = 1'b0;
          held[d] = exp_v;
        end else begin
          tt[d]++;
        end
      end
      checkOutput($sformatf("d%0d_cycle", d), 64'(dut_obs[d]), 64'(exp_v));
    end
  end

  // Observation of instance 0/1 events used by the literal checks.
  int cyc = 0, clr_cyc = 0, run_len = -1, done_cnt = 0, en_rd_diff = 0;
  bit in_run = 0;
  int cwe_q [$];
  int a1_q [$];
  int b1_q [$];
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_run = 0;
    end else begin
      if (clr0 && !in_run) begin
        clr_cyc = cyc;
        in_run = 1;
      end
      if (done0) begin
        run_len = cyc - clr_cyc;
        done_cnt++;
        in_run = 0;
      end
      if (we0) cwe_q.push_back(int'(c0));
      if (rd1) begin
        a1_q.push_back(int'(a1));
        b1_q.push_back(int'(b1));
      end
      if (en1 !== rd1) en_rd_diff++;
    end
  end

  // Behavioural one-cycle-latency memories and MAC on instance 0.
  int mem_a [4] = '{1, 2, 3, 4};
  int mem_b [4] = '{5, 6, 7, 8};
  int mem_c [4] = '{0, 0, 0, 0};
  int opa = 0, opb = 0, acc = 0;
  always @(posedge clk) begin
    if (rd0) begin
      opa <= mem_a[a0[1:0]];
      opb <= mem_b[b0[1:0]];
    end
    if (clr0) acc <= 0;
    else if (en0) acc <= acc + opa * opb;
    if (we0) mem_c[c0[1:0]] <= acc;
  end

  // Wait for all model runs to finish, bounded.
  task automatic waitIdle(input int max_cycles);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      #1;
      c++;
    end while ((act[0] || act[1] || act[2]) && c < max_cycles);
    checkOutput("idle_wait", 64'({act[2], act[1], act[0]}), 64'd0);
  endtask

  logic [2:0] sm, st;
  int gap, clr_count, guard;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_d0", 64'(dut_obs[0]), 64'd0);
    checkOutput("reset_d2", 64'(dut_obs[2]), 64'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single run on every instance.
    applyStimulus(3'b111, 3'b000);
    applyStimulus(3'b000, 3'b000);
    waitIdle(300);
    checkOutput("n2_run_len", 64'(run_len), 64'd20);
    checkOutput("n2_done_cnt", 64'(done_cnt), 64'd1);
    checkOutput("n2_cwe_cnt", 64'(cwe_q.size()), 64'd4);
    for (int x = 0; x < 4; x++)
      checkOutput($sformatf("n2_cwe_addr%0d", x), 64'(cwe_q.size() > x ? cwe_q[x] : -1), 64'(x));
    checkOutput("c00", 64'(mem_c[0]), 64'd19);
    checkOutput("c01", 64'(mem_c[1]), 64'd22);
    checkOutput("c10", 64'(mem_c[2]), 64'd43);
    checkOutput("c11", 64'(mem_c[3]), 64'd50);
    checkOutput("n3_rd_cnt", 64'(a1_q.size()), 64'd27);
    if (a1_q.size() >= 18) begin
      checkOutput("n3_e12_a0", 64'(a1_q[15]), 64'd3);
      checkOutput("n3_e12_a1", 64'(a1_q[16]), 64'd4);
      checkOutput("n3_e12_a2", 64'(a1_q[17]), 64'd5);
      checkOutput("n3_e12_b0", 64'(b1_q[15]), 64'd2);
      checkOutput("n3_e12_b1", 64'(b1_q[16]), 64'd5);
      checkOutput("n3_e12_b2", 64'(b1_q[17]), 64'd8);
    end
    checkOutput("n3_macen_eq_rden", 64'(en_rd_diff), 64'd0);

    // Start pulsed mid-MAC and held through DONE on instance 0.
    applyStimulus(3'b001, 3'b000);
    applyStimulus(3'b000, 3'b000);
    guard = 0;
    do begin @(negedge clk); #1; guard++; end while (!rd0 && guard < 50);
    applyStimulus(3'b001, 3'b000);
    applyStimulus(3'b000, 3'b000);
    applyStimulus(3'b001, 3'b000);
    guard = 0;
    do begin @(negedge clk); #1; guard++; end while (!done0 && guard < 100);
    checkOutput("run1_done_seen", 64'(done0), 64'd1);
    gap = 0;
    do begin @(negedge clk); #1; gap++; end while (!clr0 && gap < 10);
    checkOutput("done_to_clear_gap", 64'(gap), 64'd2);
    applyStimulus(3'b000, 3'b000);

    // Asynchronous reset during the MAC phase of element 2.
    clr_count = 1;
    guard = 0;
    do begin
      @(negedge clk);
      #1;
      guard++;
      if (clr0) clr_count++;
    end while (!(clr_count == 3 && rd0) && guard < 100);
    checkOutput("elem2_mac_reached", 64'(rd0), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_d0", 64'(dut_obs[0]), 64'd0);
    checkOutput("midrun_reset_d1", 64'(dut_obs[1]), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(3'b001, 3'b000);
    applyStimulus(3'b000, 3'b000);
    guard = 0;
    do begin @(negedge clk); #1; guard++; end while (!rd0 && guard < 50);
    checkOutput("restart_addr_a", 64'(a0), 64'd0);
    checkOutput("restart_addr_b", 64'(b0), 64'd0);
    waitIdle(100);

    // Random start (and stall, when present) traffic.
    for (int c = 0; c < 900; c++) begin
      st = '0;
      for (int b = 0; b < 3; b++) begin
        sm[b] = ($urandom_range(0, 15) == 0);
`ifdef MATSEQ_STALL_EN
        st[b] = ($urandom_range(0, 7) == 0);
`endif
      end
      applyStimulus(sm, st);
    end
    applyStimulus(3'b000, 3'b000);
    waitIdle(1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
